// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: hex glyph table, segment bit positions and scan FSM states.
package seg7_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Active-high {g,f,e,d,c,b,a} glyphs for 0..F, indexed by nibble value.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DWELL
    } state_t;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex nibble to 7-segment decode.
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG[nib_i];

endmodule

// File: rtl/seg_scan_scheduler.sv
// Digit scan sequencer for a 595-driven multiplexed 7-segment display, with
// frame-aligned content updates so a new value never tears across a frame.
module seg_scan_scheduler
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SHIFT_CYCLES = 34,
    parameter int DWELL_CYCLES = 1000
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    load_i,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic                    blank_i,
    output logic                    sr_trigger_o,
    output logic [15:0]             sr_data_o,
    output logic [2:0]              digit_idx_o,
    output logic                    frame_start_o
);

    localparam int CNT_MAX = (SHIFT_CYCLES > DWELL_CYCLES) ? SHIFT_CYCLES : DWELL_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    state_t                  state, state_nxt;
    logic [CW-1:0]           cnt, cnt_nxt;
    logic [2:0]              idx, idx_nxt;
    logic                    enter_load, apply;

    logic [4*NUM_DIGITS-1:0] act_dig, pend_dig, nxt_dig;
    logic [NUM_DIGITS-1:0]   act_dp, pend_dp, nxt_dp;
    logic                    pend_vld;

    logic [31:0]             dig_ext;
    logic [7:0]              dp_ext;
    logic [3:0]              nib;
    logic [6:0]              seg;
    logic [7:0]              seg_byte;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        idx_nxt    = idx;
        enter_load = 1'b0;
        apply      = 1'b0;
        case (state)
            ST_IDLE: begin
                state_nxt  = ST_LOAD;
                idx_nxt    = '0;
                enter_load = 1'b1;
            end
            ST_LOAD: begin
                state_nxt = ST_SHIFT;
                cnt_nxt   = CW'(SHIFT_CYCLES - 1);
            end
            ST_SHIFT: begin
                if (cnt == '0) begin
                    state_nxt = ST_DWELL;
                    cnt_nxt   = CW'(DWELL_CYCLES - 1);
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_DWELL: begin
                if (cnt == '0) begin
                    state_nxt  = ST_LOAD;
                    enter_load = 1'b1;
                    apply      = (idx == 3'(NUM_DIGITS - 1));
                    idx_nxt    = apply ? 3'd0 : idx + 3'd1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Content in effect for the word being loaded; a same-cycle load beats the pending buffer.
    always_comb begin
        nxt_dig = act_dig;
        nxt_dp  = act_dp;
        if (apply) begin
            if (load_i) begin
                nxt_dig = digits_i;
                nxt_dp  = dp_i;
            end else if (pend_vld) begin
                nxt_dig = pend_dig;
                nxt_dp  = pend_dp;
            end
        end
    end

    assign dig_ext = 32'(nxt_dig);
    assign dp_ext  = 8'(nxt_dp);
    assign nib     = dig_ext[{idx_nxt, 2'b00} +: 4];

    seg7_decoder u_dec (
        .nib_i (nib),
        .seg_o (seg)
    );

    always_comb begin
        seg_byte         = {1'b0, seg};
        seg_byte[SEG_DP] = dp_ext[idx_nxt];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            act_dig   <= '0;
            act_dp    <= '0;
            pend_dig  <= '0;
            pend_dp   <= '0;
            pend_vld  <= 1'b0;
            sr_data_o <= '0;
        end else begin
            if (apply) begin
                act_dig  <= nxt_dig;
                act_dp   <= nxt_dp;
                pend_vld <= 1'b0;
            end else if (load_i) begin
                pend_dig <= digits_i;
                pend_dp  <= dp_i;
                pend_vld <= 1'b1;
            end
            if (enter_load)
                sr_data_o <= blank_i ? 16'h0000 : {seg_byte, 8'd1 << idx_nxt};
        end
    end

    assign sr_trigger_o  = (state == ST_LOAD);
    assign frame_start_o = (state == ST_LOAD) && (idx == 3'd0);
    assign digit_idx_o   = idx;

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Bench for seg_scan_scheduler: directed vectors, corner sequences and a random run vs a timeline model.
module tb_seg_scan_scheduler;

    localparam int ND  = 4;
    localparam int SC  = 34;
    localparam int DC  = 8;
    localparam int PER = 1 + SC + DC;
    localparam int FR  = ND * PER;

    logic        clk = 1'b0, rst = 1'b1, load = 1'b0, blank = 1'b0;
    logic [15:0] digits = '0;
    logic [3:0]  dp = '0;
    logic        trig, fs;
    logic [15:0] sdata;
    logic [2:0]  idx;

    int compared = 0, mismatched = 0;

    seg_scan_scheduler #(.NUM_DIGITS(ND), .SHIFT_CYCLES(SC), .DWELL_CYCLES(DC)) dut (
        .clk_i(clk), .rst_i(rst), .load_i(load), .digits_i(digits), .dp_i(dp),
        .blank_i(blank), .sr_trigger_o(trig), .sr_data_o(sdata),
        .digit_idx_o(idx), .frame_start_o(fs)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Timeline model: triggers fall every PER edges after release, frame content is
    // the latest load seen up to each frame's first trigger (zeros for the first frame).
    int          n;
    logic [15:0] lat_dig, fr_dig, e_data;
    logic [3:0]  lat_dp, fr_dp;
    logic        e_trig, e_fs;
    logic [2:0]  e_idx;

    function automatic logic [15:0] word(logic [15:0] dg, logic [3:0] p, int d);
        logic [3:0] nb;
        nb = dg[d*4 +: 4];
        return {p[d], GLYPH[nb], 8'(1 << d)};
    endfunction

    task automatic model_reset();
        n = 0; lat_dig = '0; lat_dp = '0; fr_dig = '0; fr_dp = '0;
        e_data = '0; e_trig = 1'b0; e_fs = 1'b0; e_idx = '0;
    endtask

    task automatic model_step(logic ld, logic [15:0] dg, logic [3:0] p, logic blk);
        int k, d, f;
        n++;
        if (ld) begin lat_dig = dg; lat_dp = p; end
        k = n - 1;
        d = (k / PER) % ND;
        f = k / FR;
        e_trig = (k % PER == 0);
        e_fs   = e_trig && (d == 0);
        e_idx  = 3'(d);
        if (e_fs) begin
            fr_dig = (f == 0) ? 16'h0 : lat_dig;
            fr_dp  = (f == 0) ? 4'h0  : lat_dp;
        end
        if (e_trig) e_data = blk ? 16'h0000 : word(fr_dig, fr_dp, d);
    endtask

    task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(string pre);
        chk({pre, "_trigger"},     16'(trig),  16'(e_trig));
        chk({pre, "_frame_start"}, 16'(fs),    16'(e_fs));
        chk({pre, "_digit_idx"},   16'(idx),   16'(e_idx));
        chk({pre, "_sr_data"},     sdata,      e_data);
    endtask

    task automatic tick(logic ld, logic [15:0] dg, logic [3:0] p, logic blk);
        load = ld; digits = dg; dp = p; blank = blk;
        @(posedge clk);
        model_step(ld, dg, p, blk);
        @(negedge clk);
        chk_all("cycle");
        load = 1'b0;
    endtask

    task automatic idle(int k);
        repeat (k) tick(1'b0, 16'h0, 4'h0, 1'b0);
    endtask

    task automatic wait_frame();
        for (int i = 0; i < FR + PER; i++) begin
            tick(1'b0, 16'h0, 4'h0, 1'b0);
            if (fs) break;
        end
        chk("frame_wait", 16'(fs), 16'd1);
    endtask

    task automatic do_reset(bit async_chk);
        load = 1'b0; blank = 1'b0; rst = 1'b1;
        if (async_chk) begin
            #1;
            model_reset();
            chk_all("reset_async");
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        chk_all("reset_hold");
        rst = 1'b0;
    endtask

    typedef struct {
        logic [15:0]      d1;
        logic [3:0]       p1;
        bit               two;
        logic [15:0]      d2;
        logic [3:0]       p2;
        logic [3:0][15:0] exp;
    } vec_t;

    vec_t tv [4];
    int   nblank;

    initial begin
        tv[0] = '{16'hA981, 4'b0010, 1'b0, 16'h0,    4'h0, {16'h7708, 16'h6F04, 16'hFF02, 16'h0601}};
        tv[1] = '{16'h1111, 4'b0000, 1'b1, 16'h2222, 4'h0, {16'h5B08, 16'h5B04, 16'h5B02, 16'h5B01}};
        tv[2] = '{16'hF0C3, 4'b1001, 1'b0, 16'h0,    4'h0, {16'hF108, 16'h3F04, 16'h3902, 16'hCF01}};
        tv[3] = '{16'hEDB7, 4'b0100, 1'b0, 16'h0,    4'h0, {16'h7908, 16'hDE04, 16'h7C02, 16'h0701}};

        do_reset(1'b0);

        // First frame after release: cleared content, exact trigger spacing.
        tick(1'b0, 16'h0, 4'h0, 1'b0);
        chk("first_trigger", 16'(trig), 16'd1);
        chk("first_word", sdata, 16'h3F01);
        for (int d = 1; d < ND; d++) begin
            idle(PER - 1);
            chk("spacing_early", 16'(trig), 16'd0);
            tick(1'b0, 16'h0, 4'h0, 1'b0);
            chk("spacing_trigger", 16'(trig), 16'd1);
            chk("reset_frame_word", sdata, 16'h3F00 | 16'(1 << d));
        end

        // Mid-frame loads show up in the following frame only.
        for (int v = 0; v < 4; v++) begin
            wait_frame();
            idle(20);
            tick(1'b1, tv[v].d1, tv[v].p1, 1'b0);
            if (tv[v].two) begin
                idle(50);
                tick(1'b1, tv[v].d2, tv[v].p2, 1'b0);
            end
            wait_frame();
            chk("vec_word0", sdata, tv[v].exp[0]);
            for (int d = 1; d < ND; d++) begin
                idle(PER);
                chk("vec_trigger", 16'(trig), 16'd1);
                chk("vec_word", sdata, tv[v].exp[d]);
            end
        end

        // Load on the apply edge itself is used by that very word.
        wait_frame();
        idle(FR - 1);
        tick(1'b1, 16'h5555, 4'h0, 1'b0);
        chk("apply_edge_word", sdata, 16'h6D01);
        chk("apply_edge_fs", 16'(fs), 16'd1);

        // One full blanked frame, then normal again.
        wait_frame();
        idle(FR - 1);
        nblank = 0;
        for (int i = 0; i < FR; i++) begin
            tick(1'b0, 16'h0, 4'h0, 1'b1);
            if (trig) begin
                nblank++;
                chk("blank_word", sdata, 16'h0000);
            end
        end
        chk("blank_trigger_count", 16'(nblank), 16'd4);
        wait_frame();
        chk("after_blank_word", sdata, 16'h6D01);

        // Reset ten clocks into the shift window of digit 2.
        wait_frame();
        idle(2 * PER + 11);
        chk("pre_reset_idx", 16'(idx), 16'd2);
        do_reset(1'b1);
        tick(1'b0, 16'h0, 4'h0, 1'b0);
        chk("post_reset_word", sdata, 16'h3F01);
        chk("post_reset_fs", 16'(fs), 16'd1);

        // Random loads and blanking against the model, with one reset in the middle.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset(1'b1);
            tick(($urandom % 40) == 0, 16'($urandom), 4'($urandom), ($urandom % 6) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/seg_scan_scheduler.md
SEG_SCAN_SCHEDULER -- requirements
Module: seg_scan_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, giving the number of multiplexed 7-segment digits (1..8).
REQ-002 The block SHALL have parameter SHIFT_CYCLES, default 34, giving the clocks reserved for one 16-bit shift-out.
REQ-003 The block SHALL have parameter DWELL_CYCLES, default 1000, giving the clocks each digit stays lit after its shift-out window.
REQ-004 clk_i  input  1  single block clock.
REQ-005 rst_i  input  1  reset, asynchronous, active-high.
REQ-006 load_i  input  1  single-cycle request to capture new display content.
REQ-007 digits_i  input  4*NUM_DIGITS  hex nibble per digit; digit 0 is in bits [3:0].
REQ-008 dp_i  input  NUM_DIGITS  decimal point per digit.
REQ-009 blank_i  input  1  level; forces a dark display while high.
REQ-010 sr_trigger_o  output  1  one-cycle start pulse to the 595 shift-register driver.
REQ-011 sr_data_o  output  16  word to shift: [15:8] segments {dp,g,f,e,d,c,b,a}, active-high; [7:0] one-hot digit enable, active-high.
REQ-012 digit_idx_o  output  3  index of the digit currently being driven.
REQ-013 frame_start_o  output  1  one-cycle pulse coincident with the sr_trigger_o for digit 0.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, SHIFT and DWELL.
REQ-015 IDLE SHALL be left unconditionally for LOAD on the first clock after reset release.
REQ-016 In LOAD the block SHALL assert sr_trigger_o for exactly one cycle, load the counter with SHIFT_CYCLES-1 and go to SHIFT.
REQ-017 SHIFT SHALL count down and go to DWELL at count 0, loading the counter with DWELL_CYCLES-1.
REQ-018 DWELL SHALL count down and at count 0 go to LOAD with digit_idx advanced modulo NUM_DIGITS (NUM_DIGITS-1 wraps to 0).
REQ-019 Trigger-to-trigger spacing SHALL be exactly 1+SHIFT_CYCLES+DWELL_CYCLES clocks.
REQ-020 sr_data_o SHALL be registered, updated only on entry to LOAD, and held stable through SHIFT and DWELL.
REQ-021 The segment byte SHALL be the hex decode of the active nibble for the selected digit (0..F), OR dp in bit 15.
REQ-022 The enable byte SHALL be 1<<digit_idx, with bits at NUM_DIGITS and above fixed at 0.
REQ-023 When blank_i is sampled high on entry to LOAD, sr_data_o SHALL be 16'h0000 and the sequencing SHALL otherwise continue unchanged.
REQ-024 A load_i pulse SHALL capture digits_i and dp_i into a pending buffer and set a pending flag; when several loads occur before the apply point, the last one wins.
REQ-025 Pending content SHALL be copied to the active registers only on the DWELL-to-LOAD transition into digit 0, which prevents frame tearing.
REQ-026 When load_i coincides with the apply transition, the same-cycle digits_i and dp_i SHALL go directly to the active registers, and the pending flag SHALL be cleared.
REQ-027 Without a load, the active content SHALL be retained indefinitely.

Reset
REQ-028 While rst_i is high, all of the following SHALL hold, asynchronously:
- sr_trigger_o=0, frame_start_o=0, sr_data_o=16'h0000, digit_idx_o=0;
- state=IDLE, counter=0, pending flag=0;
- active and pending digits all 0, dp all 0.
REQ-029 A reset asserted mid-SHIFT or mid-DWELL SHALL abort the current scan; after release, the first trigger SHALL be for digit 0.

Structure
REQ-030 The following SHALL live in shared package seg7_pkg: the 4-to-7 hex segment table, the segment bit-position constants, and the FSM state enumeration.
REQ-031 Hex decoding SHALL be in sub-module seg7_decoder (4-bit nibble in, 7-bit segments out, combinational).
REQ-032 The block SHALL instantiate seg7_decoder once, on the selected active nibble.

Verification (NUM_DIGITS=4, SHIFT_CYCLES=34, DWELL_CYCLES=8)
REQ-033 Reset release, no load -> first trigger 1 clock after release; sr_data_o=16'h3F01, then 16'h3F02, 16'h3F04, 16'h3F08; trigger spacing 43 clocks.
REQ-034 load_i with digits_i=16'hA981, dp_i=4'b0010 mid-frame -> current frame unchanged; next frame gives 16'h0601, 16'hFF02, 16'h6F04, 16'h7708; frame_start_o fires with the first word.
REQ-035 Two loads in one frame (16'h1111, then 16'h2222) -> next frame shows digit 2 (segments 0x5B) on all positions.
REQ-036 load_i on the DWELL-to-LOAD cycle into digit 0 -> that same LOAD word already uses the new data.
REQ-037 blank_i high for one full frame -> four triggers with sr_data_o=16'h0000; the next frame after blank_i falls is normal.
REQ-038 rst_i asserted 10 clocks into SHIFT of digit 2 -> outputs 0 immediately; after release the first word is for digit 0 with cleared data (16'h3F01).
